// File: rtl/bundle_parser_n_if.sv
// bundle_parser_n_if
//  Groups the fetch-side handshake and the issue-side lane bus of bundle_parser_n.
//  Handshake: a fetch word transfers on a rising clock edge exactly when
//  fetch_valid_i and fetch_ready_o are both 1 in the cycle before that edge.
//  The producer may raise or drop valid at any time. Ready depends only on
//  registered state, never on valid. flush_i drops any word offered in its cycle.
//  The lane bus has no back-pressure handshake. stall_i freezes it instead.
//  Modports:
//   slave  - the parser: inputs flush/stall/fetch, outputs ready/lanes/counts
//   master - the driving side: fetch unit plus downstream control
interface bundle_parser_n_if #(
  parameter int ISSUE_WIDTH = 2,
  parameter int FETCH_BITS  = 64,
  parameter int BUF_BITS    = 128
);
  localparam int BYTES_W = $clog2(ISSUE_WIDTH*30/8+2);
  localparam int COUNT_W = $clog2(BUF_BITS+1);

  logic                      flush_i;
  logic                      stall_i;
  logic                      fetch_valid_i;
  logic [FETCH_BITS-1:0]     fetch_data_i;
  logic                      fetch_ready_o;
  logic [ISSUE_WIDTH-1:0]    lane_valid_o;
  logic [ISSUE_WIDTH-1:0]    lane_format_o;
  logic [ISSUE_WIDTH-1:0]    lane_branch_o;
  logic [7*ISSUE_WIDTH-1:0]  lane_opcode_o;
  logic [5*ISSUE_WIDTH-1:0]  lane_reg_o;
  logic [16*ISSUE_WIDTH-1:0] lane_operand_o;
  logic [BYTES_W-1:0]        bundle_bytes_o;
  logic [COUNT_W-1:0]        buf_count_o;

  modport slave (
    input  flush_i, stall_i, fetch_valid_i, fetch_data_i,
    output fetch_ready_o, lane_valid_o, lane_format_o, lane_branch_o,
           lane_opcode_o, lane_reg_o, lane_operand_o, bundle_bytes_o, buf_count_o
  );

  modport master (
    output flush_i, stall_i, fetch_valid_i, fetch_data_i,
    input  fetch_ready_o, lane_valid_o, lane_format_o, lane_branch_o,
           lane_opcode_o, lane_reg_o, lane_operand_o, bundle_bytes_o, buf_count_o
  );
endinterface

// File: rtl/bundle_parser_n.sv
// bundle_parser_n
//  Takes a bit-contiguous stream of 19b short and 30b long instructions in
//  fetch words. It keeps them in an MSB-aligned alignment buffer. Each cycle it
//  issues up to ISSUE_WIDTH decoded instructions in order, with lane 0 as the
//  oldest. Instructions may straddle fetch-word boundaries.
//  Ports:
//   clock_i   - clock, all state on the rising edge
//   reset_ni  - asynchronous active-low reset
//   bus       - bundle_parser_n_if.slave:
//               flush_i, stall_i, fetch_valid_i/fetch_data_i/fetch_ready_o,
//               lane_valid/format/branch/opcode/reg/operand_o,
//               bundle_bytes_o, buf_count_o
module bundle_parser_n #(
  parameter int ISSUE_WIDTH    = 2,
  parameter int FETCH_BITS     = 64,
  parameter int BUF_BITS       = 128,
  parameter bit STOP_ON_BRANCH = 1'b0
) (
  input logic               clock_i,
  input logic               reset_ni,
  bundle_parser_n_if.slave  bus
);
  localparam int CW = $clog2(BUF_BITS+1);
  localparam int OW = CW + 1;  // offsets may momentarily exceed the buffered count
  localparam int BW = $clog2(ISSUE_WIDTH*30/8+2);

  logic [BUF_BITS-1:0] buf_q, buf_d;
  logic [CW-1:0]       count_q, count_d, remain;

  logic [ISSUE_WIDTH-1:0]    valid_q, fmt_q, branch_q;
  logic [7*ISSUE_WIDTH-1:0]  opcode_q;
  logic [5*ISSUE_WIDTH-1:0]  reg_q;
  logic [16*ISSUE_WIDTH-1:0] operand_q;
  logic [BW-1:0]             bytes_q;

  logic [ISSUE_WIDTH-1:0]    p_valid, p_fmt, p_branch;
  logic [7*ISSUE_WIDTH-1:0]  p_opcode;
  logic [5*ISSUE_WIDTH-1:0]  p_reg;
  logic [16*ISSUE_WIDTH-1:0] p_operand;
  logic [OW-1:0]             p_bits, off, need, used_bits;
  logic [BW-1:0]             p_bytes;
  logic [29:0]               head;
  logic                      chain_ok, prev_branch, accept;

  // Ready looks only at the registered count, so a word is accepted only if it
  // fits even when nothing is consumed in the same cycle.
  assign bus.fetch_ready_o = (count_q <= CW'(BUF_BITS - FETCH_BITS));
  assign accept            = bus.fetch_valid_i && bus.fetch_ready_o;

  // Parse: walk the buffer from the oldest bit. Lane k looks at a 30-bit head
  // window at offset O_k. The window top holds fmt, branch, opcode and reg in
  // the same place for both formats.
  always_comb begin
    p_valid     = '0;
    p_fmt       = '0;
    p_branch    = '0;
    p_opcode    = '0;
    p_reg       = '0;
    p_operand   = '0;
    off         = '0;
    need        = '0;
    head        = '0;
    chain_ok    = 1'b1;
    prev_branch = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      head = 30'((buf_q << off) >> (BUF_BITS - 30));
      need = off + (head[29] ? OW'(30) : OW'(19));
      if (STOP_ON_BRANCH && prev_branch) chain_ok = 1'b0;
      if ({1'b0, count_q} < need)        chain_ok = 1'b0;
      if (chain_ok) begin
        p_valid[k]             = 1'b1;
        p_fmt[k]               = head[29];
        p_branch[k]            = head[28];
        p_opcode[7*k +: 7]     = head[27:21];
        p_reg[5*k +: 5]        = head[20:16];
        p_operand[16*k +: 16]  = head[29] ? head[15:0] : {11'b0, head[15:11]};
        prev_branch            = head[28];
        off                    = need;
      end
    end
    p_bits  = off;
    p_bytes = BW'((p_bits + OW'(7)) >> 3);
  end

  // Buffer update: drop consumed bits from the top, then place an accepted
  // word right after the bits that remain.
  always_comb begin
    used_bits = bus.stall_i ? '0 : p_bits;
    remain    = count_q - CW'(used_bits);
    buf_d     = buf_q << used_bits;
    if (accept) begin
      buf_d = buf_d | ({bus.fetch_data_i, {(BUF_BITS-FETCH_BITS){1'b0}}} >> remain);
    end
    count_d = remain + (accept ? CW'(FETCH_BITS) : CW'(0));
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_q     <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      fmt_q     <= '0;
      branch_q  <= '0;
      opcode_q  <= '0;
      reg_q     <= '0;
      operand_q <= '0;
      bytes_q   <= '0;
    end else if (bus.flush_i) begin
      buf_q     <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      fmt_q     <= '0;
      branch_q  <= '0;
      opcode_q  <= '0;
      reg_q     <= '0;
      operand_q <= '0;
      bytes_q   <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      if (!bus.stall_i) begin
        valid_q   <= p_valid;
        fmt_q     <= p_fmt;
        branch_q  <= p_branch;
        opcode_q  <= p_opcode;
        reg_q     <= p_reg;
        operand_q <= p_operand;
        bytes_q   <= p_bytes;
      end
    end
  end

  assign bus.lane_valid_o   = valid_q;
  assign bus.lane_format_o  = fmt_q;
  assign bus.lane_branch_o  = branch_q;
  assign bus.lane_opcode_o  = opcode_q;
  assign bus.lane_reg_o     = reg_q;
  assign bus.lane_operand_o = operand_q;
  assign bus.bundle_bytes_o = bytes_q;
  assign bus.buf_count_o    = count_q;
endmodule
